alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked execution unit: the next-generation ALU for the CPU datapath.
//  Runs all existing single-cycle ALU ops with a registered result, and adds iterative
//  multiply/divide (MULT/MULTU/DIV/DIVU), overflow, divide-by-zero and illegal-op flags.
//  Sits between decode/issue (in_* channel) and writeback (out_* channel).
// PARAMETERS
//  WIDTH   32  operand/result width; >=8, power of 2; shift amount = opr_b[$clog2(WIDTH)-1:0]
//  MDU_EN  1   1: mul/div implemented; 0: mul/div opcodes complete as illegal
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      reset, asynchronous, active-low
//  in_valid_alu_i   in   1      op/operands valid
//  in_ready_alu_o   out  1      unit can accept
//  op_alu_i         in   6      opcode (funct encoding, list below)
//  opr_a_alu_i      in   WIDTH  operand A / dividend / multiplicand
//  opr_b_alu_i      in   WIDTH  operand B / divisor / multiplier / shift amount
//  out_valid_alu_o  out  1      result valid
//  out_ready_alu_i  in   1      writeback accepts result
//  res_lo_alu_o     out  WIDTH  result; mul low half; quotient
//  res_hi_alu_o     out  WIDTH  mul high half; remainder; 0 for other ops
//  z_alu_o          out  1      res_lo == 0
//  n_alu_o          out  1      res_lo[WIDTH-1]
//  v_alu_o          out  1      signed overflow (ADD/SUB only, else 0)
//  dz_alu_o         out  1      divide by zero (DIV/DIVU only)
//  ill_alu_o        out  1      unsupported opcode
// BEHAVIOUR
//  Opcodes: ADD 100000 SUB 100010 AND 100100 OR 100101 XOR 100110 NOR 100111 SLT 101010
//   SLTU 101011 SHL 000010 LSR 000011 ASR 000100 MULT 011000 MULTU 011001 DIV 011010 DIVU 011011.
//  SLT/SLTU: res_lo = {0..0, a<b} signed/unsigned, true compare (immune to overflow).
//  FSM: IDLE, BUSY, DONE. Accept = in_valid & in_ready; operands/op captured at accept.
//  in_ready_alu_o = (state==IDLE) | (state==DONE & out_ready_alu_i) -> back-to-back issue.
//  Single-cycle/illegal ops: accept -> DONE next edge (latency 1).
//  MUL/DIV: accept -> BUSY; WIDTH iterations, one per cycle (shift-add / restoring);
//   out_valid rises WIDTH+1 cycles after accept. Signed ops: operate on magnitudes, fix signs.
//  DIV: truncating; remainder takes sign of dividend. DIV MIN/-1 -> lo=MIN, hi=0, v=0.
//  Divide by zero: skip BUSY, DONE after 1 cycle; lo=all ones, hi=dividend, dz=1.
//  Illegal op (incl. mul/div when MDU_EN=0): DONE after 1 cycle, lo=hi=0, ill=1, z=1.
//  DONE: all result/flag outputs stable while out_valid & !out_ready.
//   On out handshake: -> IDLE, or capture new op if in_valid same cycle.
//  No flush input; a started MUL/DIV always completes.
//  Reset (async, any state incl. mid-BUSY): state=IDLE, out_valid=0, in_ready=1 after
//   deassertion, all res/flag outputs 0, iteration counter 0; partial result discarded.
//  Outputs registered; no combinational path from in_* to out_* data.
// TESTING
//  ADD 0x7FFFFFFF+0x1 -> 1 cycle later lo=0x80000000, v=1, n=1, z=0, hi=0.
//  SUB 5-5 then SLT 0x80000000,0x1 back-to-back, out_ready=1 -> lo=0 z=1, then lo=1; 1 op/cycle.
//  MULT 0xFFFFFFFD*0x5 -> out_valid at accept+33: hi=0xFFFFFFFF lo=0xFFFFFFF1; in_ready=0 while BUSY.
//  DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD hi=1; DIVU 9/0 -> 1 cycle, lo=0xFFFFFFFF hi=9 dz=1.
//  Opcode 111111 -> lo=0 ill=1; out_ready low 5 cycles -> outputs frozen, in_ready=0.
//  rst_n low at BUSY iteration 10 of MULTU -> immediate out_valid=0, outputs 0; next op correct.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked execution unit.
// Single-cycle ALU ops produce a registered result one cycle after accept.
// Multiply and divide run iteratively, one bit per cycle, on operand magnitudes.
// Signs are applied when the result is written out.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int MDU_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_alu_i,
    output logic             in_ready_alu_o,
    input  logic [5:0]       op_alu_i,
    input  logic [WIDTH-1:0] opr_a_alu_i,
    input  logic [WIDTH-1:0] opr_b_alu_i,
    output logic             out_valid_alu_o,
    input  logic             out_ready_alu_i,
    output logic [WIDTH-1:0] res_lo_alu_o,
    output logic [WIDTH-1:0] res_hi_alu_o,
    output logic             z_alu_o,
    output logic             n_alu_o,
    output logic             v_alu_o,
    output logic             dz_alu_o,
    output logic             ill_alu_o
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_SHL   = 6'b000010;
    localparam logic [5:0] OP_LSR   = 6'b000011;
    localparam logic [5:0] OP_ASR   = 6'b000100;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mul_op_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   res_lo_r;
    logic [WIDTH-1:0]   res_hi_r;
    logic               z_r;
    logic               n_r;
    logic               v_r;
    logic               dz_r;
    logic               ill_r;

    logic               accept_s;
    logic               in_ready_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [SH_W-1:0]    shamt_s;
    logic               alu_legal_s;
    logic               mdu_s;
    logic [WIDTH-1:0]   alu_lo_s;
    logic               alu_v_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic               ld_busy_s;
    logic [WIDTH-1:0]   ld_lo_s;
    logic [WIDTH-1:0]   ld_hi_s;
    logic               ld_v_s;
    logic               ld_dz_s;
    logic               ld_ill_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_diff_s;
    logic [WIDTH-1:0]   nxt_hi_s;
    logic [WIDTH-1:0]   nxt_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fin_lo_s;
    logic [WIDTH-1:0]   fin_hi_s;

    // Handshake: ready when idle, or when the held result leaves this cycle.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready_alu_i);
        accept_s   = in_valid_alu_i & in_ready_s;
    end

    assign in_ready_alu_o  = in_ready_s;
    assign out_valid_alu_o = (state_r == ST_DONE);
    assign res_lo_alu_o    = res_lo_r;
    assign res_hi_alu_o    = res_hi_r;
    assign z_alu_o         = z_r;
    assign n_alu_o         = n_r;
    assign v_alu_o         = v_r;
    assign dz_alu_o        = dz_r;
    assign ill_alu_o       = ill_r;

    // Single-cycle ALU datapath and opcode classification.
    always_comb begin
        sum_s       = opr_a_alu_i + opr_b_alu_i;
        diff_s      = opr_a_alu_i - opr_b_alu_i;
        shamt_s     = opr_b_alu_i[SH_W-1:0];
        alu_legal_s = 1'b1;
        mdu_s       = 1'b0;
        alu_lo_s    = {WIDTH{1'b0}};
        alu_v_s     = 1'b0;
        case (op_alu_i)
            OP_ADD: begin
                alu_lo_s = sum_s;
                alu_v_s  = (opr_a_alu_i[WIDTH-1] == opr_b_alu_i[WIDTH-1]) &
                           (sum_s[WIDTH-1] != opr_a_alu_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo_s = diff_s;
                alu_v_s  = (opr_a_alu_i[WIDTH-1] != opr_b_alu_i[WIDTH-1]) &
                           (diff_s[WIDTH-1] != opr_a_alu_i[WIDTH-1]);
            end
            OP_AND:  alu_lo_s = opr_a_alu_i & opr_b_alu_i;
            OP_OR:   alu_lo_s = opr_a_alu_i | opr_b_alu_i;
            OP_XOR:  alu_lo_s = opr_a_alu_i ^ opr_b_alu_i;
            OP_NOR:  alu_lo_s = ~(opr_a_alu_i | opr_b_alu_i);
            OP_SLT:  alu_lo_s = {{(WIDTH-1){1'b0}}, ($signed(opr_a_alu_i) < $signed(opr_b_alu_i))};
            OP_SLTU: alu_lo_s = {{(WIDTH-1){1'b0}}, (opr_a_alu_i < opr_b_alu_i)};
            OP_SHL:  alu_lo_s = opr_a_alu_i << shamt_s;
            OP_LSR:  alu_lo_s = opr_a_alu_i >> shamt_s;
            OP_ASR:  alu_lo_s = WIDTH'($signed(opr_a_alu_i) >>> shamt_s);
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                alu_legal_s = 1'b0;
                mdu_s       = (MDU_EN != 0) ? 1'b1 : 1'b0;
            end
            default: alu_legal_s = 1'b0;
        endcase
    end

    // Operand magnitudes for mul/div; op bit 0 clear means a signed variant.
    always_comb begin
        sign_a_s = mdu_s & ~op_alu_i[0] & opr_a_alu_i[WIDTH-1];
        sign_b_s = mdu_s & ~op_alu_i[0] & opr_b_alu_i[WIDTH-1];
        mag_a_s  = sign_a_s ? (~opr_a_alu_i + {{(WIDTH-1){1'b0}}, 1'b1}) : opr_a_alu_i;
        mag_b_s  = sign_b_s ? (~opr_b_alu_i + {{(WIDTH-1){1'b0}}, 1'b1}) : opr_b_alu_i;
    end

    // What an accepted op does: finish now (alu, dz, illegal) or start iterating.
    always_comb begin
        ld_busy_s = 1'b0;
        ld_lo_s   = {WIDTH{1'b0}};
        ld_hi_s   = {WIDTH{1'b0}};
        ld_v_s    = 1'b0;
        ld_dz_s   = 1'b0;
        ld_ill_s  = 1'b0;
        if (alu_legal_s) begin
            ld_lo_s = alu_lo_s;
            ld_v_s  = alu_v_s;
        end else if (mdu_s) begin
            if (op_alu_i[1] && (opr_b_alu_i == {WIDTH{1'b0}})) begin
                ld_lo_s = {WIDTH{1'b1}};
                ld_hi_s = opr_a_alu_i;
                ld_dz_s = 1'b1;
            end else begin
                ld_busy_s = 1'b1;
            end
        end else begin
            ld_ill_s = 1'b1;
        end
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_diff_s = {acc_hi_r, acc_lo_r[WIDTH-1]} - {1'b0, opb_r};
        if (mul_op_r) begin
            nxt_hi_s = mul_sum_s[WIDTH:1];
            nxt_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH]) begin
            nxt_hi_s = div_diff_s[WIDTH-1:0];
            nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi_s = {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
            nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up applied to the finished magnitude result.
    always_comb begin
        prod_s = {acc_hi_r, acc_lo_r};
        if (mul_op_r) begin
            prod_s   = neg_lo_r ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
            fin_lo_s = prod_s[WIDTH-1:0];
            fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end else begin
            fin_lo_s = neg_lo_r ? (~acc_lo_r + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_lo_r;
            fin_hi_s = neg_hi_r ? (~acc_hi_r + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_hi_r;
        end
    end

    // Control FSM, iteration registers and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            mul_op_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            res_lo_r <= {WIDTH{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            v_r      <= 1'b0;
            dz_r     <= 1'b0;
            ill_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (ld_busy_s) begin
                            state_r  <= ST_BUSY;
                            cnt_r    <= {CNT_W{1'b0}};
                            mul_op_r <= ~op_alu_i[1];
                            neg_lo_r <= sign_a_s ^ sign_b_s;
                            neg_hi_r <= op_alu_i[1] ? sign_a_s : (sign_a_s ^ sign_b_s);
                            acc_hi_r <= {WIDTH{1'b0}};
                            acc_lo_r <= op_alu_i[1] ? mag_a_s : mag_b_s;
                            opb_r    <= op_alu_i[1] ? mag_b_s : mag_a_s;
                        end else begin
                            state_r  <= ST_DONE;
                            res_lo_r <= ld_lo_s;
                            res_hi_r <= ld_hi_s;
                            z_r      <= (ld_lo_s == {WIDTH{1'b0}});
                            n_r      <= ld_lo_s[WIDTH-1];
                            v_r      <= ld_v_s;
                            dz_r     <= ld_dz_s;
                            ill_r    <= ld_ill_s;
                        end
                    end else if ((state_r == ST_DONE) && out_ready_alu_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CNT_W'(WIDTH)) begin
                        state_r  <= ST_DONE;
                        cnt_r    <= {CNT_W{1'b0}};
                        res_lo_r <= fin_lo_s;
                        res_hi_r <= fin_hi_s;
                        z_r      <= (fin_lo_s == {WIDTH{1'b0}});
                        n_r      <= fin_lo_s[WIDTH-1];
                        v_r      <= 1'b0;
                        dz_r     <= 1'b0;
                        ill_r    <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                        acc_hi_r <= nxt_hi_s;
                        acc_lo_r <= nxt_lo_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq with hand-computed expected values.
module tb_alu_seq;

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_SHL   = 6'b000010;
    localparam logic [5:0] OP_LSR   = 6'b000011;
    localparam logic [5:0] OP_ASR   = 6'b000100;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        z, n, v, dz, ill;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(32), .MDU_EN(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid_alu_i  (in_valid),
        .in_ready_alu_o  (in_ready),
        .op_alu_i        (op),
        .opr_a_alu_i     (opr_a),
        .opr_b_alu_i     (opr_b),
        .out_valid_alu_o (out_valid),
        .out_ready_alu_i (out_ready),
        .res_lo_alu_o    (res_lo),
        .res_hi_alu_o    (res_hi),
        .z_alu_o         (z),
        .n_alu_o         (n),
        .v_alu_o         (v),
        .dz_alu_o        (dz),
        .ill_alu_o       (ill)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        opr_a    = a;
        opr_b    = b;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for out_valid after an accept; reports cycles and whether in_ready was seen.
    task automatic wait_done(output int cyc, output logic saw_ready);
        cyc       = 0;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc = cyc + 1;
            if (out_valid) break;
            if (in_ready) saw_ready = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 6'd0;
        opr_a     = 32'd0;
        opr_b     = 32'd0;
        #12;
        n_checks++;
        if ({out_valid, z, n, v, dz, ill} !== 6'b000000)
            $display("FAIL reset_flags: got %b want %b", {out_valid, z, n, v, dz, ill}, 6'b000000);
        else n_pass++;
        n_checks++;
        if ({res_lo, res_hi} !== 64'd0)
            $display("FAIL reset_res: got %h want %h", {res_lo, res_hi}, 64'd0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want %b", in_ready, 1'b1);
        else n_pass++;
    endtask

    task automatic test_add_overflow;
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, v, n, z, dz, ill} !== 6'b111000)
            $display("FAIL add_flags: got %b want %b", {out_valid, v, n, z, dz, ill}, 6'b111000);
        else n_pass++;
        n_checks++;
        if ({res_hi, res_lo} !== 64'h0000_0000_8000_0000)
            $display("FAIL add_res: got %h want %h", {res_hi, res_lo}, 64'h0000_0000_8000_0000);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL add_drain: got %b want %b", out_valid, 1'b0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        drive(OP_SUB, 32'd5, 32'd5);
        tick();
        n_checks++;
        if ({out_valid, z, in_ready, res_lo} !== {3'b111, 32'd0})
            $display("FAIL b2b_sub: got %b/%h want 111/%h", {out_valid, z, in_ready}, res_lo, 32'd0);
        else n_pass++;
        drive(OP_SLT, 32'h8000_0000, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, z, res_lo} !== {2'b10, 32'd1})
            $display("FAIL b2b_slt: got %b/%h want 10/%h", {out_valid, z}, res_lo, 32'd1);
        else n_pass++;
        tick();
    endtask

    task automatic test_alu_ops;
        logic [5:0]  t_op;
        logic [31:0] t_a, t_b, t_lo;
        logic        t_v;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:  begin t_op = OP_AND;  t_a = 32'hF0F0_F0F0; t_b = 32'hFF00_FF00; t_lo = 32'hF000_F000; t_v = 1'b0; end
                1:  begin t_op = OP_OR;   t_a = 32'hF0F0_F0F0; t_b = 32'h0F0F_0000; t_lo = 32'hFFFF_F0F0; t_v = 1'b0; end
                2:  begin t_op = OP_XOR;  t_a = 32'hFFFF_0000; t_b = 32'h0F0F_0F0F; t_lo = 32'hF0F0_0F0F; t_v = 1'b0; end
                3:  begin t_op = OP_NOR;  t_a = 32'h0000_0000; t_b = 32'h0000_0000; t_lo = 32'hFFFF_FFFF; t_v = 1'b0; end
                4:  begin t_op = OP_SLTU; t_a = 32'h0000_0001; t_b = 32'h8000_0000; t_lo = 32'h0000_0001; t_v = 1'b0; end
                5:  begin t_op = OP_SLT;  t_a = 32'h0000_0001; t_b = 32'h8000_0000; t_lo = 32'h0000_0000; t_v = 1'b0; end
                6:  begin t_op = OP_SHL;  t_a = 32'h0000_0001; t_b = 32'h0000_0024; t_lo = 32'h0000_0010; t_v = 1'b0; end
                7:  begin t_op = OP_LSR;  t_a = 32'h8000_0000; t_b = 32'h0000_001F; t_lo = 32'h0000_0001; t_v = 1'b0; end
                8:  begin t_op = OP_ASR;  t_a = 32'h8000_0000; t_b = 32'h0000_0004; t_lo = 32'hF800_0000; t_v = 1'b0; end
                9:  begin t_op = OP_SUB;  t_a = 32'h8000_0000; t_b = 32'h0000_0001; t_lo = 32'h7FFF_FFFF; t_v = 1'b1; end
                default: begin t_op = OP_ADD; t_a = 32'h0000_0001; t_b = 32'h0000_0001; t_lo = 32'h0000_0002; t_v = 1'b0; end
            endcase
            drive(t_op, t_a, t_b);
            tick();
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, v, res_lo, res_hi} !== {1'b1, t_v, t_lo, 32'd0})
                $display("FAIL alu_vec%0d: got v=%b lo=%h hi=%h want v=%b lo=%h hi=0", i, v, res_lo, res_hi, t_v, t_lo);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mult;
        int   cyc;
        logic saw_ready;
        drive(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL mult_busy: got %b want %b", {out_valid, in_ready}, 2'b00);
        else n_pass++;
        wait_done(cyc, saw_ready);
        n_checks++;
        if (cyc !== 33 || saw_ready !== 1'b0)
            $display("FAIL mult_latency: got %0d ready_seen=%b want 33 ready_seen=0", cyc, saw_ready);
        else n_pass++;
        n_checks++;
        if ({res_hi, res_lo, n, z} !== {64'hFFFF_FFFF_FFFF_FFF1, 2'b10})
            $display("FAIL mult_res: got %h%h want %h", res_hi, res_lo, 64'hFFFF_FFFF_FFFF_FFF1);
        else n_pass++;
        tick();
    endtask

    task automatic test_div;
        int   cyc;
        logic saw_ready;
        drive(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        tick();
        in_valid = 1'b0;
        wait_done(cyc, saw_ready);
        n_checks++;
        if (cyc !== 33 || {res_lo, res_hi, dz} !== {32'hFFFF_FFFD, 32'd1, 1'b0})
            $display("FAIL div_signed: got cyc=%0d lo=%h hi=%h dz=%b want cyc=33 lo=fffffffd hi=1 dz=0", cyc, res_lo, res_hi, dz);
        else n_pass++;
        tick();
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        wait_done(cyc, saw_ready);
        n_checks++;
        if (cyc !== 33 || {res_lo, res_hi, v} !== {32'h8000_0000, 32'd0, 1'b0})
            $display("FAIL div_min: got cyc=%0d lo=%h hi=%h v=%b want lo=80000000 hi=0 v=0", cyc, res_lo, res_hi, v);
        else n_pass++;
        tick();
        drive(OP_DIVU, 32'd100, 32'd7);
        tick();
        in_valid = 1'b0;
        wait_done(cyc, saw_ready);
        n_checks++;
        if ({res_lo, res_hi} !== {32'd14, 32'd2})
            $display("FAIL divu: got lo=%h hi=%h want lo=%h hi=%h", res_lo, res_hi, 32'd14, 32'd2);
        else n_pass++;
        tick();
        drive(OP_DIVU, 32'd9, 32'd0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, dz, ill, res_lo, res_hi} !== {3'b110, 32'hFFFF_FFFF, 32'd9})
            $display("FAIL div_zero: got vld=%b dz=%b lo=%h hi=%h want vld=1 dz=1 lo=ffffffff hi=9", out_valid, dz, res_lo, res_hi);
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal_stall;
        logic held_ok;
        out_ready = 1'b0;
        drive(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        n_checks++;
        if ({out_valid, ill, z, res_lo, res_hi} !== {3'b111, 64'd0})
            $display("FAIL illegal_res: got vld=%b ill=%b z=%b lo=%h hi=%h want 1 1 1 0 0", out_valid, ill, z, res_lo, res_hi);
        else n_pass++;
        drive(OP_ADD, 32'd1, 32'd1);
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, ill, in_ready, res_lo} !== {3'b110, 32'd0}) held_ok = 1'b0;
            tick();
        end
        n_checks++;
        if (held_ok !== 1'b1)
            $display("FAIL stall_hold: got %b want %b", held_ok, 1'b1);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL stall_release_ready: got %b want %b", in_ready, 1'b1);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, ill, res_lo} !== {2'b10, 32'd2})
            $display("FAIL stall_next: got vld=%b ill=%b lo=%h want 1 0 %h", out_valid, ill, res_lo, 32'd2);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_busy;
        int   cyc;
        logic saw_ready;
        drive(OP_MULTU, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, res_lo, res_hi, z, n, v, dz, ill} !== {2'b01, 69'd0})
            $display("FAIL busy_reset: got vld=%b rdy=%b lo=%h hi=%h want 0 1 0 0", out_valid, in_ready, res_lo, res_hi);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(OP_MULTU, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        wait_done(cyc, saw_ready);
        n_checks++;
        if (cyc !== 33 || {res_hi, res_lo} !== 64'd12)
            $display("FAIL post_reset_multu: got cyc=%0d res=%h%h want cyc=33 res=%h", cyc, res_hi, res_lo, 64'd12);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_alu_ops();
        test_mult();
        test_div();
        test_illegal_stall();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
